// File: rtl/rf_wport_arb_pkg.sv
// Shared types for the register-file write-port arbiter.
// Entry layout and FSM encoding used by the arbiter and its FIFO.
package rf_wport_arb_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        IDLE,
        FORCE
    } state_t;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } aux_entry_t;

endpackage

// File: rtl/rf_wport_arb_if.sv
// WB, auxiliary handshake, decode and RF write-port signals.
// The arbiter takes the slave view; the pipeline side drives the master view.
interface rf_wport_arb_if;

    logic        WbWe;
    logic [4:0]  WbA;
    logic [31:0] WbD;
    logic        AuxValid;
    logic        AuxReady;
    logic [4:0]  AuxA;
    logic [31:0] AuxD;
    logic        AuxIssue;
    logic [4:0]  AuxIssueA;
    logic [4:0]  RdA1;
    logic [4:0]  RdA2;
    logic        Hazard;
    logic        Stall;
    logic        We;
    logic [4:0]  A3;
    logic [31:0] WD;

    modport slave (
        input  WbWe, WbA, WbD,
        input  AuxValid, AuxA, AuxD,
        input  AuxIssue, AuxIssueA,
        input  RdA1, RdA2,
        output AuxReady, Hazard, Stall,
        output We, A3, WD
    );

    modport master (
        output WbWe, WbA, WbD,
        output AuxValid, AuxA, AuxD,
        output AuxIssue, AuxIssueA,
        output RdA1, RdA2,
        input  AuxReady, Hazard, Stall,
        input  We, A3, WD
    );

endinterface

// File: rtl/rf_wport_arb_aux_fifo.sv
// Small synchronous FIFO for auxiliary results, async active-high reset.
// Head is a read-through of the oldest entry; push/pop are guarded internally.
module aux_fifo
    import rf_wport_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          Push,
    input  logic          Pop,
    input  aux_entry_t    Din,
    output logic          Full,
    output logic          Empty,
    output logic [AW:0]   Count,
    output aux_entry_t    Head
);

    aux_entry_t      mem [DEPTH];
    logic [AW-1:0]   rd;
    logic [AW-1:0]   wr;
    logic            push_ok;
    logic            pop_ok;

    assign Full    = (Count == (AW+1)'(DEPTH));
    assign Empty   = (Count == '0);
    assign push_ok = Push & ~Full;
    assign pop_ok  = Pop & ~Empty;
    assign Head    = mem[rd];

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rd    <= '0;
            wr    <= '0;
            Count <= '0;
        end else begin
            if (push_ok) wr <= wr + 1'b1;
            if (pop_ok)  rd <= rd + 1'b1;
            Count <= Count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    // Storage needs no reset: Count gates every read of it.
    always_ff @(posedge Clk) begin
        if (push_ok) mem[wr] <= Din;
    end

endmodule

// File: rtl/rf_wport_arb.sv
// RF write-port arbiter: WB has fixed priority, aux results queue in a FIFO,
// a scoreboard flags pending aux destinations and starvation forces a drain.
module rf_wport_arb
    import rf_wport_arb_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int STARVE = 4
) (
    input  logic            Clk,
    input  logic            Rst,
    rf_wport_arb_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE + 1);
    localparam logic [CW-1:0] CMAX = CW'(STARVE);

    logic            full;
    logic            empty;
    logic [AW:0]     count;
    logic [AW:0]     count_nx;
    aux_entry_t      head;
    aux_entry_t      din;
    logic            push;
    logic            pop;
    logic            wb_win;
    logic [31:0]     busy;
    logic [31:0]     busy_d;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_d;
    state_t          state;
    state_t          state_d;

    assign din      = '{addr: bus.AuxA, data: bus.AuxD};
    assign bus.AuxReady = ~full;
    assign push     = bus.AuxValid & ~full;
    assign wb_win   = bus.WbWe & (bus.WbA != REG_ZERO);
    assign pop      = ~wb_win & ~empty;
    assign count_nx = count + (AW+1)'(push) - (AW+1)'(pop);

    aux_fifo #(.DEPTH(DEPTH)) u_fifo (
        .Clk   (Clk),
        .Rst   (Rst),
        .Push  (push),
        .Pop   (pop),
        .Din   (din),
        .Full  (full),
        .Empty (empty),
        .Count (count),
        .Head  (head)
    );

    always_comb begin
        bus.We = 1'b0;
        bus.A3 = REG_ZERO;
        bus.WD = '0;
        if (wb_win) begin
            bus.We = 1'b1;
            bus.A3 = bus.WbA;
            bus.WD = bus.WbD;
        end else if (!empty) begin
            bus.We = (head.addr != REG_ZERO);
            bus.A3 = head.addr;
            bus.WD = head.data;
        end
    end

    // A reservation issued in the pop cycle must survive the clear.
    always_comb begin
        busy_d = busy;
        if (pop) busy_d[head.addr] = 1'b0;
        if (bus.AuxIssue) busy_d[bus.AuxIssueA] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) busy <= '0;
        else     busy <= busy_d;
    end

    assign bus.Hazard = busy[bus.RdA1] | busy[bus.RdA2];

    always_comb begin
        cnt_d = '0;
        if (!empty && !pop) cnt_d = (cnt == CMAX) ? cnt : cnt + 1'b1;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt   <= '0;
            state <= IDLE;
        end else begin
            cnt   <= cnt_d;
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:  if (cnt_d == CMAX) state_d = FORCE;
            FORCE: if (count_nx == '0) state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.Stall = (state == FORCE);
    end

endmodule

// File: tb/tb_rf_wport_arb.sv
// Scoreboard bench for rf_wport_arb: a queue-based reference model predicts
// each cycle's RF write; a monitor pops and compares whenever the DUT writes.
module tb_rf_wport_arb;
    import rf_wport_arb_pkg::*;

    localparam int DEPTH  = 2;
    localparam int STARVE = 4;

    logic Clk = 1'b0;
    logic Rst;
    always #5 Clk = ~Clk;

    rf_wport_arb_if ifc ();

    rf_wport_arb #(.DEPTH(DEPTH), .STARVE(STARVE)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (ifc)
    );

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    int checks = 0;
    int errors = 0;

    wr_t        exp_q[$];
    aux_entry_t mq[$];
    bit         mbusy[32];
    int         mcnt;
    bit         mstall;

    bit          s_rst;
    bit          s_we;
    logic [4:0]  s_wa;
    logic [31:0] s_wd;
    bit          s_av;
    logic [4:0]  s_aa;
    logic [31:0] s_ad;
    bit          s_iss;
    logic [4:0]  s_ia;
    logic [4:0]  s_r1;
    logic [4:0]  s_r2;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic clr();
        s_we = 0; s_wa = 0; s_wd = 0;
        s_av = 0; s_aa = 0; s_ad = 0;
        s_iss = 0; s_ia = 0; s_r1 = 0; s_r2 = 0;
    endtask

    task automatic step();
        bit         wbwin;
        bit         nonempty;
        bit         pop;
        bit         push;
        aux_entry_t h;
        @(negedge Clk);
        Rst = s_rst;
        ifc.WbWe = s_we; ifc.WbA = s_wa; ifc.WbD = s_wd;
        ifc.AuxValid = s_av; ifc.AuxA = s_aa; ifc.AuxD = s_ad;
        ifc.AuxIssue = s_iss; ifc.AuxIssueA = s_ia;
        ifc.RdA1 = s_r1; ifc.RdA2 = s_r2;
        #1;
        if (s_rst) begin
            mq.delete();
            foreach (mbusy[i]) mbusy[i] = 0;
            mcnt = 0;
            mstall = 0;
        end
        wbwin = s_we && (s_wa != 0);
        chk("aux_ready", ifc.AuxReady, 32'(mq.size() < DEPTH));
        chk("hazard", ifc.Hazard, 32'(mbusy[s_r1] | mbusy[s_r2]));
        chk("stall", ifc.Stall, 32'(mstall));
        if (wbwin) exp_q.push_back('{s_wa, s_wd});
        else if (mq.size() > 0 && mq[0].addr != 0)
            exp_q.push_back('{mq[0].addr, mq[0].data});
        if (!s_rst) begin
            nonempty = mq.size() > 0;
            pop  = !wbwin && nonempty;
            push = s_av && (mq.size() < DEPTH);
            if (pop) begin
                h = mq.pop_front();
                mbusy[h.addr] = 0;
            end
            if (s_iss && s_ia != 0) mbusy[s_ia] = 1;
            if (push) mq.push_back('{s_aa, s_ad});
            if (nonempty && !pop) mcnt = (mcnt < STARVE) ? mcnt + 1 : mcnt;
            else mcnt = 0;
            if (!mstall) mstall = (mcnt == STARVE);
            else mstall = (mq.size() != 0);
        end
    endtask

    wr_t e;
    always @(negedge Clk) begin
        #2;
        if (ifc.We !== 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write actual=%0h:%0h required=none",
                         ifc.A3, ifc.WD);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(ifc.A3), 32'(e.a));
                chk("wr_data", ifc.WD, e.d);
            end
        end else if (exp_q.size() > 0) begin
            checks++; errors++;
            $display("FAIL missing_write actual=none required=%0h:%0h",
                     exp_q[0].a, exp_q[0].d);
            exp_q.delete();
        end
    end

    initial begin
        Rst = 1'b1;
        ifc.WbWe = 0; ifc.WbA = 0; ifc.WbD = 0;
        ifc.AuxValid = 0; ifc.AuxA = 0; ifc.AuxD = 0;
        ifc.AuxIssue = 0; ifc.AuxIssueA = 0;
        ifc.RdA1 = 0; ifc.RdA2 = 0;
        mcnt = 0; mstall = 0;
        clr();

        s_rst = 1; step(); step();
        s_rst = 0; step(); step();

        // Reserve r5, deliver its result, watch Hazard fall after the pop.
        s_iss = 1; s_ia = 5; s_r1 = 5; step();
        clr(); s_r1 = 5; s_av = 1; s_aa = 5; s_ad = 32'h1234; step();
        clr(); s_r1 = 5; step(); step(); step();

        // WB hogs the port while r7 and r8 queue up; starvation forces a drain.
        for (int i = 0; i < 6; i++) begin
            clr();
            s_we = 1; s_wa = 3; s_wd = 32'hA000 + 32'(i);
            s_r1 = 7; s_r2 = 8;
            if (i < 2) begin
                s_av = 1; s_aa = 5'(7 + i); s_ad = 32'hB000 + 32'(i);
                s_iss = 1; s_ia = 5'(7 + i);
            end
            step();
        end
        for (int i = 0; i < 4; i++) begin
            clr(); s_r1 = 7; s_r2 = 8; step();
        end

        // Entry for $0 is discarded.
        clr(); s_av = 1; s_aa = 0; s_ad = 32'hDEAD; step();
        clr(); step(); step();

        // Re-reservation of r9 in its own pop cycle keeps it busy.
        clr(); s_iss = 1; s_ia = 9; s_r1 = 9; step();
        clr(); s_av = 1; s_aa = 9; s_ad = 32'h99; s_r1 = 9; step();
        clr(); s_iss = 1; s_ia = 9; s_r1 = 9; step();
        clr(); s_r1 = 9; step(); step();
        clr(); s_av = 1; s_aa = 9; s_ad = 32'h999; s_r2 = 9; step();
        clr(); s_r2 = 9; step(); step();

        // Reset with two entries queued and Stall high.
        for (int i = 0; i < 7; i++) begin
            clr();
            s_we = 1; s_wa = 4; s_wd = 32'hC000 + 32'(i);
            if (i < 2) begin
                s_av = 1; s_aa = 5'(12 + i); s_ad = 32'hD000 + 32'(i);
                s_iss = 1; s_ia = 5'(12 + i);
            end
            s_r1 = 12; s_r2 = 13;
            step();
        end
        clr(); s_rst = 1; s_r1 = 12; s_r2 = 13; step();
        s_rst = 0; step(); step(); step();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            clr();
            s_we  = mstall ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) == 0);
            s_wa  = 5'($urandom_range(0, 15));
            s_wd  = $urandom;
            s_av  = $urandom_range(0, 1);
            s_aa  = 5'($urandom_range(0, 15));
            s_ad  = $urandom;
            s_iss = ($urandom_range(0, 3) == 0);
            s_ia  = 5'($urandom_range(0, 15));
            s_r1  = 5'($urandom_range(0, 15));
            s_r2  = 5'($urandom_range(0, 15));
            s_rst = ($urandom_range(0, 99) == 0);
            step();
        end
        s_rst = 0;
        clr(); step(); step(); step(); step();
        #2;
        chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
